// File: rtl/perips_pkg.sv
// perips_pkg: shared widths, default address map and router FSM states
package perips_pkg;
    localparam int WB_AD_WIDTH = 32;
    localparam int WB_DAT_WIDTH = 32;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
    localparam int DEF_SLV_SHIFT = 12;
    typedef enum logic [1:0] {IDLE, REQ, RESP_ACK, RESP_ERR} router_state_e;
endpackage

// File: rtl/wb_periph_router_if.sv
// wb_periph_router_if: single-master Wishbone link between axi2wb and the router
interface wb_periph_router_if #(
    parameter int AW = perips_pkg::WB_AD_WIDTH,
    parameter int DW = perips_pkg::WB_DAT_WIDTH
);
    logic cyc;
    logic stb;
    logic we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] sel;
    logic [DW-1:0] rdata;
    logic ack;
    logic err;
    modport master(output cyc, stb, we, addr, wdata, sel, input rdata, ack, err);
    modport slave(input cyc, stb, we, addr, wdata, sel, output rdata, ack, err);
endinterface

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: maps a byte address onto a fixed-stride slave index
module wb_addr_decode #(
    parameter int NUM_SLAVES = 7,
    parameter int AW = 32,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter int SLV_SHIFT = 12,
    parameter int IW = 3
) (
    input  logic [AW-1:0] addr,
    output logic [IW-1:0] idx,
    output logic mapped
);
    logic [AW-1:0] off;
    logic [AW-1:0] slot;
    assign off = addr - BASE_ADDR;
    assign slot = off >> SLV_SHIFT;
    assign mapped = (addr >= BASE_ADDR) && (slot < AW'(NUM_SLAVES));
    assign idx = slot[IW-1:0];
endmodule

// File: rtl/wb_periph_router.sv
// wb_periph_router: registered Wishbone router with unmapped-error, timeout watchdog and error status
module wb_periph_router
    import perips_pkg::*;
#(
    parameter int NUM_SLAVES = 7,
    parameter int WB_AD_WIDTH = perips_pkg::WB_AD_WIDTH,
    parameter int WB_DAT_WIDTH = perips_pkg::WB_DAT_WIDTH,
    parameter logic [WB_AD_WIDTH-1:0] BASE_ADDR = perips_pkg::DEF_BASE_ADDR,
    parameter int SLV_SHIFT = perips_pkg::DEF_SLV_SHIFT,
    parameter int TIMEOUT_CYC = 255,
    parameter logic [WB_DAT_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic clk,
    input  logic rst,
    wb_periph_router_if.slave chip,
    output logic [NUM_SLAVES-1:0] wbm_slave_cyc_o,
    output logic [NUM_SLAVES-1:0] wbm_slave_stb_o,
    output logic wbm_slave_we_o,
    output logic [WB_AD_WIDTH-1:0] wbm_slave_addr_o,
    output logic [WB_DAT_WIDTH-1:0] wbm_slave_wdata_o,
    output logic [WB_DAT_WIDTH/8-1:0] wbm_slave_sel_o,
    input  logic [NUM_SLAVES-1:0][WB_DAT_WIDTH-1:0] slave_wbm_rdata_i,
    input  logic [NUM_SLAVES-1:0] slave_wbm_ack_i,
    output logic [7:0] err_count_o,
    output logic [WB_AD_WIDTH-1:0] err_addr_o,
    input  logic err_clr_i
);
    localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    router_state_e state, state_nx;
    logic [IW-1:0] idx, idx_q;
    logic mapped;
    logic [CW-1:0] cnt;
    logic [WB_DAT_WIDTH-1:0] rdata_q;
    logic req, sel_ack, tmo;
    wb_addr_decode #(
        .NUM_SLAVES(NUM_SLAVES),
        .AW(WB_AD_WIDTH),
        .BASE_ADDR(BASE_ADDR),
        .SLV_SHIFT(SLV_SHIFT),
        .IW(IW)
    ) u_dec (
        .addr(chip.addr),
        .idx(idx),
        .mapped(mapped)
    );
    assign req = chip.cyc & chip.stb;
    assign sel_ack = slave_wbm_ack_i[idx_q];
    assign tmo = cnt == CW'(TIMEOUT_CYC);
    assign chip.rdata = rdata_q;
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end
    // next state and decoded outputs; master abort beats ack, ack beats timeout
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: state_nx = !req ? IDLE : mapped ? REQ : RESP_ERR;
            REQ: state_nx = !chip.cyc ? IDLE : sel_ack ? RESP_ACK : tmo ? RESP_ERR : REQ;
            default: state_nx = IDLE;
        endcase
        chip.ack = state == RESP_ACK;
        chip.err = state == RESP_ERR;
        wbm_slave_cyc_o = state == REQ ? NUM_SLAVES'(1) << idx_q : '0;
        wbm_slave_stb_o = wbm_slave_cyc_o;
    end
    // request latch, watchdog counter and response data
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            cnt <= '0;
            rdata_q <= '0;
            wbm_slave_we_o <= 1'b0;
            wbm_slave_addr_o <= '0;
            wbm_slave_wdata_o <= '0;
            wbm_slave_sel_o <= '0;
        end else begin
            if (state == IDLE && req) begin
                idx_q <= idx;
                cnt <= '0;
                wbm_slave_we_o <= chip.we;
                wbm_slave_addr_o <= chip.addr;
                wbm_slave_wdata_o <= chip.wdata;
                wbm_slave_sel_o <= chip.sel;
                rdata_q <= mapped ? rdata_q : ERR_RDATA;
            end
            if (state == REQ) begin
                cnt <= cnt + 1'b1;
                rdata_q <= sel_ack ? slave_wbm_rdata_i[idx_q] : tmo ? ERR_RDATA : rdata_q;
            end
        end
    end
    // sticky error status; a clear beats an error being logged in the same cycle
    always_ff @(posedge clk) begin
        if (rst || err_clr_i) begin
            err_count_o <= '0;
            err_addr_o <= '0;
        end else if (state == RESP_ERR) begin
            err_count_o <= err_count_o + {7'd0, ~&err_count_o};
            err_addr_o <= wbm_slave_addr_o;
        end
    end
endmodule

// File: tb/tb_wb_periph_router.sv
// tb_wb_periph_router: directed transfers checked every cycle against a cycle-indexed expectation model
module tb_wb_periph_router;
    localparam int NS = 7;
    localparam int TO = 4;
    localparam int NC = 2048;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    logic clk = 0;
    logic rst = 1;
    logic err_clr = 0;
    logic [NS-1:0] s_cyc, s_stb;
    logic [NS-1:0] ack_i = '0;
    logic s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0] s_sel;
    logic [NS-1:0][31:0] rdata_i;
    logic [7:0] err_count;
    logic [31:0] err_addr;
    int cyc_n = 0;
    int pass_n = 0;
    int tot_n = 0;
    int exp_port[NC];
    bit exp_ack[NC];
    bit exp_err[NC];
    logic [31:0] exp_rd[NC];
    logic [31:0] exp_ea[NC];
    logic [31:0] e_addr, e_wd;
    logic e_we;
    logic [3:0] e_sel;
    int m_cnt = 0;
    logic [31:0] m_ea = '0;
    int last_ack_c = -1;
    int last_err_c = -1;
    logic [31:0] last_rd = '0;
    int clr_cycle = -1;
    int t0;

    wb_periph_router_if chip();

    wb_periph_router #(.NUM_SLAVES(NS), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .chip(chip),
        .wbm_slave_cyc_o(s_cyc),
        .wbm_slave_stb_o(s_stb),
        .wbm_slave_we_o(s_we),
        .wbm_slave_addr_o(s_addr),
        .wbm_slave_wdata_o(s_wdata),
        .wbm_slave_sel_o(s_sel),
        .slave_wbm_rdata_i(rdata_i),
        .slave_wbm_ack_i(ack_i),
        .err_count_o(err_count),
        .err_addr_o(err_addr),
        .err_clr_i(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic void check(string n, logic [31:0] act, logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s @cycle %0d: got %h, expected %h", n, cyc_n, act, exp);
    endfunction

    // per-cycle comparison against the model, then advance the error-status model
    always @(negedge clk) begin : cmp
        int c;
        logic [NS-1:0] eo;
        if (cyc_n >= 1 && cyc_n < NC) begin
            c = cyc_n;
            eo = exp_port[c] >= 0 ? NS'(1) << exp_port[c] : '0;
            check("slv_cyc", 32'(s_cyc), 32'(eo));
            check("slv_stb", 32'(s_stb), 32'(eo));
            if (exp_port[c] >= 0) begin
                check("slv_addr", s_addr, e_addr);
                check("slv_we", 32'(s_we), 32'(e_we));
                check("slv_wdata", s_wdata, e_wd);
                check("slv_sel", 32'(s_sel), 32'(e_sel));
            end
            check("ack", 32'(chip.ack), 32'(exp_ack[c]));
            check("err", 32'(chip.err), 32'(exp_err[c]));
            if (exp_ack[c] || exp_err[c]) check("rdata", chip.rdata, exp_rd[c]);
            check("err_count", 32'(err_count), 32'(m_cnt));
            check("err_addr", err_addr, m_ea);
            if (chip.ack === 1'b1) begin last_ack_c = c; last_rd = chip.rdata; end
            if (chip.err === 1'b1) begin last_err_c = c; last_rd = chip.rdata; end
            if (rst || err_clr) begin
                m_cnt = 0;
                m_ea = '0;
            end else if (exp_err[c]) begin
                m_cnt = m_cnt == 255 ? 255 : m_cnt + 1;
                m_ea = exp_ea[c];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one master access: dly arguments are cycles after the first slave-strobe cycle, -1 = never
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                        input int ack_dly, input logic [31:0] ack_dat, input int sp_port, input int sp_dly,
                        input int drop_dly, input int rst_dly, output int ts);
        int st, p, e_end, r, kind;
        bit mp;
        st = cyc_n;
        ts = st;
        mp = (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + NS * 4096);
        p = mp ? int'((a - BASE) / 4096) : -1;
        e_addr = a; e_we = w; e_wd = d; e_sel = s;
        kind = 0;
        e_end = st + 1 + TO;
        if (ack_dly >= 0 && st + 1 + ack_dly <= e_end) begin e_end = st + 1 + ack_dly; kind = 1; end
        if (drop_dly >= 0 && st + 1 + drop_dly <= e_end) begin e_end = st + 1 + drop_dly; kind = 2; end
        if (rst_dly >= 0 && st + 1 + rst_dly <= e_end) begin e_end = st + 1 + rst_dly; kind = 2; end
        if (!mp) begin
            r = st + 1;
            exp_err[r] = 1; exp_rd[r] = ERRD; exp_ea[r] = a;
        end else begin
            for (int t = st + 1; t <= e_end; t++) exp_port[t] = p;
            r = kind == 2 ? e_end : e_end + 1;
            if (kind == 1) begin exp_ack[r] = 1; exp_rd[r] = ack_dat; end
            if (kind == 0) begin exp_err[r] = 1; exp_rd[r] = ERRD; exp_ea[r] = a; end
        end
        chip.addr = a; chip.we = w; chip.wdata = d; chip.sel = s;
        for (int cur = st; cur <= r; cur++) begin
            chip.cyc = !(drop_dly >= 0 && cur >= st + 1 + drop_dly);
            chip.stb = chip.cyc;
            ack_i = '0;
            if (p >= 0 && ack_dly >= 0 && cur == st + 1 + ack_dly) begin ack_i[p] = 1'b1; rdata_i[p] = ack_dat; end
            if (sp_port >= 0 && cur == st + 1 + sp_dly) begin ack_i[sp_port] = 1'b1; rdata_i[sp_port] = 32'hBAD0_0000 | sp_port; end
            rst = rst_dly >= 0 && cur == st + 1 + rst_dly;
            err_clr = cur == clr_cycle;
            tick();
        end
        chip.cyc = 0; chip.stb = 0; ack_i = '0; rst = 0; err_clr = 0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin exp_port[i] = -1; exp_ack[i] = 0; exp_err[i] = 0; exp_rd[i] = '0; exp_ea[i] = '0; end
        for (int i = 0; i < NS; i++) rdata_i[i] = 32'hF0F0_0000 | i;
        chip.cyc = 0; chip.stb = 0; chip.we = 0; chip.addr = '0; chip.wdata = '0; chip.sel = '0;
        rst = 1;
        repeat (3) tick();
        rst = 0;
        check("rst_ack", 32'(chip.ack), 0);
        check("rst_err", 32'(chip.err), 0);
        check("rst_rdata", chip.rdata, 0);
        check("rst_slv_cyc", 32'(s_cyc), 0);
        check("rst_slv_addr", s_addr, 0);
        check("rst_err_count", 32'(err_count), 0);
        tick();
        xfer(32'h1000_2004, 0, 0, 4'hF, 3, 32'h1234_5678, -1, 0, -1, -1, t0);
        check("t1_ack_latency", 32'(last_ack_c - t0), 5);
        check("t1_rdata", last_rd, 32'h1234_5678);
        xfer(32'h1000_7000, 0, 0, 4'hF, -1, 0, -1, 0, -1, -1, t0);
        check("t2_err_latency", 32'(last_err_c - t0), 1);
        check("t2_rdata", last_rd, 32'hDEAD_BEEF);
        check("t2_err_count", 32'(err_count), 1);
        check("t2_err_addr", err_addr, 32'h1000_7000);
        xfer(32'h1000_4010, 1, 32'hAABB_CCDD, 4'b0101, -1, 0, -1, 0, -1, -1, t0);
        check("t3_timeout_latency", 32'(last_err_c - t0), 6);
        check("t3_err_count", 32'(err_count), 2);
        xfer(32'h1000_1008, 0, 0, 4'hF, 4, 32'hCAFE_0001, 3, 1, -1, -1, t0);
        check("t4_ack_latency", 32'(last_ack_c - t0), 6);
        check("t4_no_err", 32'(last_err_c < t0), 1);
        check("t4_rdata", last_rd, 32'hCAFE_0001);
        xfer(32'h1000_0000, 0, 0, 4'hF, -1, 0, -1, 0, 2, -1, t0);
        check("t5_no_ack", 32'(last_ack_c < t0), 1);
        check("t5_no_err", 32'(last_err_c < t0), 1);
        xfer(32'h1000_6FFC, 0, 0, 4'hF, 0, 32'h0600_0006, -1, 0, -1, -1, t0);
        check("t5_next_latency", 32'(last_ack_c - t0), 2);
        check("t5_next_rdata", last_rd, 32'h0600_0006);
        xfer(32'h0FFF_FFFC, 1, 32'h1111_2222, 4'h3, -1, 0, -1, 0, -1, -1, t0);
        check("below_base_err_addr", err_addr, 32'h0FFF_FFFC);
        check("below_base_count", 32'(err_count), 3);
        xfer(32'h1000_5000, 1, 32'h5555_AAAA, 4'hF, -1, 0, -1, 0, -1, 2, t0);
        check("rst_mid_no_resp", 32'(last_ack_c < t0 && last_err_c < t0), 1);
        check("rst_mid_count", 32'(err_count), 0);
        for (int i = 0; i < 300; i++)
            xfer(i % 2 ? 32'h1000_7000 + 32'(i * 4) : 32'h0000_0100 + 32'(i * 4), 0, 0, 4'hF, -1, 0, -1, 0, -1, -1, t0);
        check("t6_saturated", 32'(err_count), 255);
        check("t6_last_addr", err_addr, 32'h1000_7000 + 32'(299 * 4));
        clr_cycle = cyc_n + 1;
        xfer(32'h2000_0000, 0, 0, 4'hF, -1, 0, -1, 0, -1, -1, t0);
        clr_cycle = -1;
        check("t6_clr_count", 32'(err_count), 0);
        check("t6_clr_addr", err_addr, 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
